dispatch: RTL and testbench

Dispatch stage, directly downstream of rename. Each cycle it accepts an in-order prefix of the rename bundle and returns per-slot `rename` acknowledges to the rename queue. It tracks physical-register busy state and per-issue-queue credits, and registers the accepted group, with source-ready bits, into a one-entry output stage toward the issue queues.

---
 rtl/dispatch_pkg.sv | 28 ++
 rtl/dispatch_busy_table.sv | 48 ++++
 rtl/dispatch.sv | 139 +++++++++++++
 tb/tb_dispatch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types for the rename -> dispatch -> issue path.
// Holds the redirect, rename and dispatch bundles.
package dispatch_pkg;

   localparam int PRW = 6;
   localparam int FUW = 2;

   typedef struct packed {
      logic [15:0] opid;
      logic        rollback;
   } red_bundle_t;

   typedef struct packed {
      logic [15:0]          opid;
      logic [1:0][PRW-1:0]  prsa;
      logic [1:0][PRW-1:0]  prda;
      logic [FUW-1:0]       fu;
   } ren_bundle_t;

   typedef struct packed {
      logic [15:0]          opid;
      logic [1:0][PRW-1:0]  prsa;
      logic [1:0][PRW-1:0]  prda;
      logic [FUW-1:0]       fu;
      logic [1:0]           rdy;
   } dis_bundle_t;

endpackage

// File: rtl/dispatch_busy_table.sv
// Physical register busy bits: set on allocation, cleared on writeback.
// Ports: clk, rst, set_en/set_prd, clr_en/clr_prd, rd_prd -> rd_busy.
module busy_table #(
   parameter int prnum = 64,
   parameter int rwd   = 2,
   parameter int iwd   = 2,
   localparam int PW   = $clog2(prnum)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [rwd-1:0]             set_en,
   input  logic [rwd-1:0][PW-1:0]     set_prd,
   input  logic [iwd-1:0]             clr_en,
   input  logic [iwd-1:0][PW-1:0]     clr_prd,
   input  logic [2*rwd-1:0][PW-1:0]   rd_prd,
   output logic [2*rwd-1:0]           rd_busy
);

   logic [prnum-1:0] busy;
   logic [prnum-1:0] busy_nxt;

   // sets applied after clears so a reallocated register stays busy
   always_comb begin
      busy_nxt = busy;
      for (int c = 0; c < iwd; c++)
         if (clr_en[c]) busy_nxt[clr_prd[c]] = 1'b0;
      for (int s = 0; s < rwd; s++)
         if (set_en[s]) busy_nxt[set_prd[s]] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   // same-cycle writeback bypass on the read side
   always_comb begin
      rd_busy = '0;
      for (int r = 0; r < 2*rwd; r++) begin
         rd_busy[r] = busy[rd_prd[r]];
         for (int c = 0; c < iwd; c++)
            if (clr_en[c] && clr_prd[c] == rd_prd[r])
               rd_busy[r] = 1'b0;
      end
   end

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: in-order prefix acceptance, credits, source readiness.
// Ports: clk, rst, red_bundle, ren_bundle/rename, wb_*, cred_ret, dis_*.
module dispatch
   import dispatch_pkg::*;
#(
   parameter int rwd    = 2,
   parameter int iwd    = 2,
   parameter int prnum  = 64,
   parameter int nfu    = 4,
   parameter int iqcred = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  red_bundle_t                       red_bundle,
   input  ren_bundle_t [rwd-1:0]             ren_bundle,
   output logic [rwd-1:0]                    rename,
   input  logic [iwd-1:0]                    wb_valid,
   input  logic [iwd-1:0][$clog2(prnum)-1:0] wb_prd,
   input  logic [nfu-1:0]                    cred_ret,
   output logic                              dis_valid,
   output dis_bundle_t [rwd-1:0]             dis_bundle,
   input  logic                              dis_ready
);

   localparam int PW = $clog2(prnum);
   localparam int FW = $clog2(nfu);
   localparam int CW = $clog2(iqcred + 1);

   logic                      flush;
   logic                      ok;
   logic [FW-1:0]             q;
   logic [rwd-1:0]            acc;
   logic [nfu-1:0][CW-1:0]    cred;
   logic [nfu-1:0][CW-1:0]    used;
   logic [nfu-1:0][CW:0]      cred_sum;
   logic [rwd-1:0]            set_en;
   logic [rwd-1:0][PW-1:0]    set_prd;
   logic [2*rwd-1:0][PW-1:0]  rd_prd;
   logic [2*rwd-1:0]          rd_busy;
   logic                      dep;
   dis_bundle_t [rwd-1:0]     cap;

   assign flush = red_bundle.opid[15];

   // a slot needs more credits than earlier accepted slots already took
   always_comb begin
      used = '0;
      acc  = '0;
      q    = '0;
      ok   = !rst && !flush && !red_bundle.rollback
             && (!dis_valid || dis_ready);
      for (int i = 0; i < rwd; i++) begin
         q = ren_bundle[i].fu[FW-1:0];
         if (ok && ren_bundle[i].opid[15] && cred[q] > used[q]) begin
            acc[i]  = 1'b1;
            used[q] = used[q] + CW'(1);
         end else begin
            ok = 1'b0;
         end
      end
   end

   assign rename = acc;

   always_comb begin
      for (int f = 0; f < nfu; f++)
         cred_sum[f] = {1'b0, cred[f]} + (CW+1)'(cred_ret[f])
                       - {1'b0, used[f]};
   end

   always_ff @(posedge clk) begin
      for (int f = 0; f < nfu; f++) begin
         if (rst || flush) begin
            cred[f] <= CW'(iqcred);
         end else begin
            assert (cred_sum[f] <= (CW+1)'(iqcred));
            cred[f] <= cred_sum[f][CW-1:0];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < rwd; i++) begin
         set_en[i]      = acc[i] && ren_bundle[i].prda[1] != '0;
         set_prd[i]     = ren_bundle[i].prda[1];
         rd_prd[2*i]    = ren_bundle[i].prsa[0];
         rd_prd[2*i+1]  = ren_bundle[i].prsa[1];
      end
   end

   busy_table #(
      .prnum (prnum),
      .rwd   (rwd),
      .iwd   (iwd)
   ) u_busy (
      .clk     (clk),
      .rst     (rst),
      .set_en  (set_en),
      .set_prd (set_prd),
      .clr_en  (wb_valid),
      .clr_prd (wb_prd),
      .rd_prd  (rd_prd),
      .rd_busy (rd_busy)
   );

   // readiness also bypasses destinations of earlier slots in this group
   always_comb begin
      dep = 1'b0;
      for (int i = 0; i < rwd; i++) begin
         cap[i].opid = acc[i] ? ren_bundle[i].opid : '0;
         cap[i].prsa = ren_bundle[i].prsa;
         cap[i].prda = ren_bundle[i].prda;
         cap[i].fu   = ren_bundle[i].fu;
         for (int k = 0; k < 2; k++) begin
            dep = 1'b0;
            for (int j = 0; j < i; j++)
               if (acc[j] && ren_bundle[j].prda[1] == ren_bundle[i].prsa[k])
                  dep = 1'b1;
            cap[i].rdy[k] = ren_bundle[i].prsa[k] == '0
                            || (!rd_busy[2*i+k] && !dep);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dis_valid  <= 1'b0;
         dis_bundle <= '0;
      end else if (flush) begin
         dis_valid  <= 1'b0;
      end else if (|acc) begin
         dis_valid  <= 1'b1;
         dis_bundle <= cap;
      end else if (dis_ready) begin
         dis_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for dispatch: acceptance, readiness, credits, redirect.
// Two instances: default credits and single-credit queues.
module tb_dispatch;
   import dispatch_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   red_bundle_t          red;
   logic [1:0]           wb_valid;
   logic [1:0][5:0]      wb_prd;
   ren_bundle_t [1:0]    ren0, ren1;
   logic [1:0]           rename0, rename1;
   logic [3:0]           cred_ret0, cred_ret1;
   logic                 dis_valid0, dis_valid1;
   dis_bundle_t [1:0]    dis0, dis1;
   logic                 dis_ready0, dis_ready1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dispatch #(.iqcred(8)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .red_bundle (red),
      .ren_bundle (ren0),
      .rename     (rename0),
      .wb_valid   (wb_valid),
      .wb_prd     (wb_prd),
      .cred_ret   (cred_ret0),
      .dis_valid  (dis_valid0),
      .dis_bundle (dis0),
      .dis_ready  (dis_ready0)
   );

   dispatch #(.iqcred(1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .red_bundle (red),
      .ren_bundle (ren1),
      .rename     (rename1),
      .wb_valid   (wb_valid),
      .wb_prd     (wb_prd),
      .cred_ret   (cred_ret1),
      .dis_valid  (dis_valid1),
      .dis_bundle (dis1),
      .dis_ready  (dis_ready1)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic ren_bundle_t op(input logic [15:0] id,
                                      input logic [5:0] s0,
                                      input logic [5:0] s1,
                                      input logic [5:0] d,
                                      input logic [1:0] fu);
      ren_bundle_t r;
      r         = '0;
      r.opid    = id;
      r.prsa[0] = s0;
      r.prsa[1] = s1;
      r.prda[1] = d;
      r.fu      = fu;
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      ren0      = '0;
      ren1      = '0;
      wb_valid  = '0;
      wb_prd    = '0;
      cred_ret0 = '0;
      cred_ret1 = '0;
      red       = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      dis_ready0 = 1'b1;
      dis_ready1 = 1'b1;
      ren0[0] = op(16'h8001, 3, 4, 10, 0);
      ren1[0] = op(16'h8001, 3, 4, 10, 0);
      tick();
      #1;
      check("rst_rename0", 32'(rename0), 32'h0);
      check("rst_rename1", 32'(rename1), 32'h0);
      tick();
      check("rst_valid0", 32'(dis_valid0), 32'h0);
      check("rst_valid1", 32'(dis_valid1), 32'h0);

      // two independent ops
      rst = 1'b0;
      idle();
      ren0[0] = op(16'h8001, 3, 4, 10, 0);
      ren0[1] = op(16'h8002, 4, 3, 11, 1);
      #1;
      check("t1_rename", 32'(rename0), 32'h3);
      tick();
      check("t1_valid", 32'(dis_valid0), 32'h1);
      check("t1_rdy0", 32'(dis0[0].rdy), 32'h3);
      check("t1_rdy1", 32'(dis0[1].rdy), 32'h3);
      check("t1_opid1", 32'(dis0[1].opid), 32'h8002);

      // busy from last cycle, plus in-group dependency on 12
      ren0[0] = op(16'h8003, 10, 11, 12, 0);
      ren0[1] = op(16'h8004, 12, 0, 13, 1);
      #1;
      check("t2_rename", 32'(rename0), 32'h3);
      tick();
      check("t2_rdy0", 32'(dis0[0].rdy), 32'h0);
      check("t2_rdy1", 32'(dis0[1].rdy), 32'h2);

      idle();
      tick();
      check("t3_drain", 32'(dis_valid0), 32'h0);

      wb_valid  = 2'b01;
      wb_prd[0] = 6'd12;
      tick();

      // 12 written back earlier, 13 bypassed this cycle
      idle();
      ren0[0]   = op(16'h8005, 12, 13, 14, 0);
      wb_valid  = 2'b01;
      wb_prd[0] = 6'd13;
      #1;
      check("t5_rename", 32'(rename0), 32'h1);
      tick();
      check("t5_rdy", 32'(dis0[0].rdy), 32'h3);
      check("t5_opid1", 32'(dis0[1].opid), 32'h0);
      check("t5_valid", 32'(dis_valid0), 32'h1);

      // backpressure
      idle();
      dis_ready0 = 1'b0;
      ren0[0] = op(16'h8006, 0, 0, 15, 3);
      ren0[1] = op(16'h8007, 0, 0, 16, 3);
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_rename", 32'(rename0), 32'h0);
         tick();
         check("bp_opid", 32'(dis0[0].opid), 32'h8005);
         check("bp_valid", 32'(dis_valid0), 32'h1);
      end
      dis_ready0 = 1'b1;
      #1;
      check("bp_release", 32'(rename0), 32'h3);
      tick();
      check("bp_new0", 32'(dis0[0].opid), 32'h8006);
      check("bp_new1", 32'(dis0[1].opid), 32'h8007);

      // writeback and allocation of 20 in one cycle
      idle();
      ren0[0]   = op(16'h8008, 0, 0, 20, 0);
      wb_valid  = 2'b01;
      wb_prd[0] = 6'd20;
      #1;
      check("t10_rename", 32'(rename0), 32'h1);
      tick();

      idle();
      ren0[0] = op(16'h8009, 20, 0, 21, 1);
      ren0[1] = op(16'h800a, 21, 15, 22, 1);
      #1;
      check("t11_rename", 32'(rename0), 32'h3);
      tick();
      check("set_wins", 32'(dis0[0].rdy), 32'h2);
      check("grp_dep", 32'(dis0[1].rdy), 32'h0);

      idle();
      tick();

      // single-credit queues
      ren1[0] = op(16'h8101, 0, 0, 30, 2);
      ren1[1] = op(16'h8102, 0, 0, 31, 2);
      #1;
      check("cr_first", 32'(rename1), 32'h1);
      tick();
      cred_ret1 = 4'b0100;
      #1;
      check("cr_ret_same", 32'(rename1), 32'h0);
      tick();
      cred_ret1 = '0;
      #1;
      check("cr_ret_next", 32'(rename1), 32'h1);
      tick();
      ren1[0] = op(16'h8103, 0, 0, 32, 3);
      ren1[1] = '0;
      #1;
      check("cr_q3", 32'(rename1), 32'h1);
      tick();
      check("cr_valid", 32'(dis_valid1), 32'h1);

      // redirect with held group and empty queues
      dis_ready1 = 1'b0;
      ren1[0]    = op(16'h8104, 0, 0, 33, 2);
      ren1[1]    = op(16'h8105, 0, 0, 34, 3);
      red.opid   = 16'h8000;
      cred_ret1  = 4'b0100;
      #1;
      check("redir_rename", 32'(rename1), 32'h0);
      tick();
      check("redir_valid", 32'(dis_valid1), 32'h0);
      red       = '0;
      cred_ret1 = '0;
      #1;
      check("redir_cred", 32'(rename1), 32'h3);
      tick();
      check("redir_cap", 32'(dis_valid1), 32'h1);

      // rollback
      dis_ready1   = 1'b1;
      red.rollback = 1'b1;
      ren1[0] = op(16'h8106, 0, 0, 35, 0);
      ren1[1] = op(16'h8107, 0, 0, 36, 1);
      ren0[0] = op(16'h800b, 0, 0, 23, 0);
      for (int c = 0; c < 2; c++) begin
         #1;
         check("rb_rename1", 32'(rename1), 32'h0);
         check("rb_rename0", 32'(rename0), 32'h0);
         tick();
         check("rb_drain", 32'(dis_valid1), 32'h0);
      end
      red = '0;
      #1;
      check("rb_end", 32'(rename1), 32'h3);
      tick();

      // reset mid-operation
      rst = 1'b1;
      #1;
      check("mid_rst_rename", 32'(rename1), 32'h0);
      tick();
      check("mid_rst_valid", 32'(dis_valid1), 32'h0);
      rst = 1'b0;
      #1;
      check("mid_rst_cred", 32'(rename1), 32'h3);
      tick();
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
